// File: rtl/maze_move_ctrl.sv
// Debounce-free pushbutton front end and move arbiter for the maze datapath.
// Define MAZE_MOVE_AUTOREPEAT_EN to re-arm a held direction every REPEAT_TICKS ticks.
module maze_move_ctrl #(
  parameter int SYNC_STAGES  = 2,
  parameter int REPEAT_TICKS = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       btn_l,
  input  logic       btn_r,
  input  logic       btn_c,
  output logic [2:0] move,
  output logic       C,
  output logic       pending
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    RELEASE = 2'd2
  } state_t;

  localparam logic [2:0] MV_STAY  = 3'b000;
  localparam logic [2:0] MV_LEFT  = 3'b001;
  localparam logic [2:0] MV_RIGHT = 3'b010;
  localparam logic [2:0] MV_DOWN  = 3'b011;
  localparam logic [2:0] MV_UP    = 3'b100;

  if (SYNC_STAGES < 2 || REPEAT_TICKS < 1) begin : g_param_check
    $error("maze_move_ctrl: SYNC_STAGES must be >= 2 and REPEAT_TICKS >= 1");
  end

  // Bit order of direction vectors: [0]=up [1]=down [2]=left [3]=right.
  function automatic logic [2:0] dir_code(input logic [3:0] d);
    if (d[0])      dir_code = MV_UP;
    else if (d[1]) dir_code = MV_DOWN;
    else if (d[2]) dir_code = MV_LEFT;
    else if (d[3]) dir_code = MV_RIGHT;
    else           dir_code = MV_STAY;
  endfunction

  logic [4:0]                   btn_raw;
  logic [SYNC_STAGES-1:0][4:0]  sync_q;
  logic [4:0]                   lvl;
  logic [4:0]                   prev_q;
  logic [4:0]                   press_q;
  logic [SYNC_STAGES:0]         flush_q;
  state_t                       state_q, state_d;
  logic [2:0]                   code_d;

  assign btn_raw = {btn_c, btn_r, btn_l, btn_d, btn_u};
  assign lvl     = sync_q[SYNC_STAGES-1];

  // flush_q fills with ones after reset so RELEASE does not trust the
  // zeroed synchronisers before real button levels have propagated.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= '0;
      prev_q  <= '0;
      press_q <= '0;
      flush_q <= '0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn_raw};
      prev_q  <= lvl;
      press_q <= lvl & ~prev_q;
      flush_q <= {flush_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

`ifdef MAZE_MOVE_AUTOREPEAT_EN
  localparam int CW = $clog2(REPEAT_TICKS + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    held, held_q;
  logic          rpt_ok_q;

  assign held = dir_code(lvl[3:0]);

  // rpt_ok_q blocks repeats of a button that was held through reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= '0;
      held_q   <= MV_STAY;
      rpt_ok_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      held_q <= held;
      if (state_q == IDLE) rpt_ok_q <= 1'b1;
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    code_d  = move;
`ifdef MAZE_MOVE_AUTOREPEAT_EN
    cnt_d   = '0;
`endif
    case (state_q)
      IDLE: begin
        if (|press_q[3:0]) begin
          code_d  = dir_code(press_q[3:0]);
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (tick) state_d = RELEASE;
      end
      RELEASE: begin
        if (&flush_q && lvl[3:0] == 4'b0000) begin
          state_d = IDLE;
        end
`ifdef MAZE_MOVE_AUTOREPEAT_EN
        else if (held != MV_STAY && held == held_q && rpt_ok_q) begin
          if (tick) begin
            if (cnt_q == CW'(REPEAT_TICKS - 1)) begin
              code_d  = held;
              state_d = ARMED;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
`endif
      end
      default: state_d = RELEASE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RELEASE;
      move    <= MV_STAY;
      pending <= 1'b0;
      C       <= 1'b0;
    end else begin
      state_q <= state_d;
      move    <= (state_d == ARMED) ? code_d : MV_STAY;
      pending <= (state_d == ARMED);
      C       <= C ? ~tick : press_q[4];
    end
  end

endmodule

// File: tb/tb_maze_move_ctrl.sv
// Scoreboard bench for maze_move_ctrl: a history-based reference model
// queues expected outputs each edge, a negedge monitor compares.
module tb_maze_move_ctrl;

  localparam int S = 2;
`ifdef MAZE_MOVE_AUTOREPEAT_EN
  localparam int RT = 2;
`else
  localparam int RT = 8;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       tick = 1'b0;
  logic [4:0] btn = 5'b0;  // [0]=u [1]=d [2]=l [3]=r [4]=c
  logic [2:0] move;
  logic       C;
  logic       pending;

  maze_move_ctrl #(.SYNC_STAGES(S), .REPEAT_TICKS(RT)) dut (
    .clk(clk), .reset(reset), .tick(tick),
    .btn_u(btn[0]), .btn_d(btn[1]), .btn_l(btn[2]), .btn_r(btn[3]), .btn_c(btn[4]),
    .move(move), .C(C), .pending(pending)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [2:0] mv;
    logic       p;
    logic       c;
  } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // h[i] is the raw button vector sampled i edges ago.
  logic [4:0] h [0:S+2];
  int         mode;       // 0 waiting for a press, 1 move offered, 2 waiting for release
  logic [2:0] m_code;
  logic       m_c;
  int         m_edges;    // clean edges since reset
`ifdef MAZE_MOVE_AUTOREPEAT_EN
  int         m_cnt;
  logic [2:0] m_prev_held;
  bit         m_rpt_ok;
`endif

  function automatic logic [2:0] prio(input logic [3:0] d);
    if (d[0]) return 3'd4;
    if (d[1]) return 3'd3;
    if (d[2]) return 3'd1;
    if (d[3]) return 3'd2;
    return 3'd0;
  endfunction

  task automatic model_step();
    exp_t e;
    logic [4:0] lvl, prs;
    logic [2:0] held;
    int old_mode;
    if (reset) begin
      for (int i = 0; i <= S + 2; i++) h[i] = 5'b0;
      mode = 2; m_code = 3'd0; m_c = 1'b0; m_edges = 0;
`ifdef MAZE_MOVE_AUTOREPEAT_EN
      m_cnt = 0; m_prev_held = 3'd0; m_rpt_ok = 1'b0;
`endif
    end else begin
      for (int i = S + 2; i > 0; i--) h[i] = h[i-1];
      h[0] = btn;
      // Levels/presses as visible to the decision made at this edge.
      lvl  = h[S];
      prs  = h[S+1] & ~h[S+2];
      held = prio(lvl[3:0]);
      old_mode = mode;
`ifdef MAZE_MOVE_AUTOREPEAT_EN
      begin
        int c_old;
        c_old = m_cnt;
        m_cnt = 0;
`endif
        if (mode == 0) begin
          if (prs[3:0] != 4'b0) begin m_code = prio(prs[3:0]); mode = 1; end
        end else if (mode == 1) begin
          if (tick) mode = 2;
        end else begin
          if (m_edges >= S + 1 && lvl[3:0] == 4'b0) mode = 0;
`ifdef MAZE_MOVE_AUTOREPEAT_EN
          else if (held != 3'd0 && held == m_prev_held && m_rpt_ok) begin
            if (tick) begin
              if (c_old + 1 == RT) begin m_code = held; mode = 1; end
              else m_cnt = c_old + 1;
            end else m_cnt = c_old;
          end
`endif
        end
`ifdef MAZE_MOVE_AUTOREPEAT_EN
      end
      m_prev_held = held;
      if (old_mode == 0) m_rpt_ok = 1'b1;
`else
      if (old_mode < 0 || held > 3'd4) mode = 2;  // never taken; keeps locals referenced
`endif
      if (m_c) begin
        if (tick) m_c = 1'b0;
      end else if (prs[4]) m_c = 1'b1;
      m_edges++;
    end
    e.mv = (mode == 1) ? m_code : 3'd0;
    e.p  = (mode == 1);
    e.c  = m_c;
    exp_q.push_back(e);
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- monitor ----------------
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (reset) e = '0;  // reset acts asynchronously
      chk("move", int'(move), int'(e.mv));
      chk("pending", int'(pending), int'(e.p));
      chk("C", int'(C), int'(e.c));
      chk("move_legal", int'(move <= 3'd4), 1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_pulse();
    tick = 1'b1;
    step();
    tick = 1'b0;
  endtask

  initial begin
    reset = 1'b1; btn = 5'b0; tick = 1'b0;
    #1;
    chk("rst_move", int'(move), 0);
    chk("rst_pending", int'(pending), 0);
    chk("rst_C", int'(C), 0);
    repeat (3) step();
    reset = 1'b0;
    repeat (6) step();

    // single left press, tick 10 cycles later
    btn[2] = 1'b1; step(); step(); btn[2] = 1'b0; step();
    chk("lat_before", int'(move), 0);
    step();
    chk("lat_at", int'(move), 1);
    chk("lat_pending", int'(pending), 1);
    repeat (6) step();
    tick = 1'b1;
    chk("tick_cycle_move", int'(move), 1);
    step(); tick = 1'b0;
    chk("after_tick_move", int'(move), 0);
    chk("after_tick_pending", int'(pending), 0);
    repeat (4) step();

    // up and right together
    btn[0] = 1'b1; btn[3] = 1'b1;
    repeat (4) step();
    chk("prio_up", int'(move), 4);
    btn = 5'b0;
    tick_pulse();
    repeat (4) step();

    // down held across three ticks
    btn[1] = 1'b1;
    repeat (5) step();
    chk("held_down", int'(move), 3);
    for (int k = 0; k < 3; k++) begin
      tick_pulse();
      repeat (3) step();
    end
    btn[1] = 1'b0;
    repeat (5) step();

`ifdef MAZE_MOVE_AUTOREPEAT_EN
    // right held, re-armed every RT ticks in RELEASE
    btn[3] = 1'b1;
    repeat (5) step();
    chk("rpt_first", int'(move), 2);
    tick_pulse(); step();
    tick_pulse(); step();
    tick_pulse();
    chk("rpt_rearm", int'(move), 2);
    for (int k = 0; k < 6; k++) begin
      tick_pulse(); step(); step();
    end
    btn[3] = 1'b0;
    tick_pulse();
    repeat (5) step();
`endif

    // reset while ARMED with up still held
    btn[0] = 1'b1;
    repeat (5) step();
    chk("pre_rst_armed", int'(move), 4);
    reset = 1'b1;
    #1;
    chk("rst_async_move", int'(move), 0);
    chk("rst_async_pending", int'(pending), 0);
    step();
    reset = 1'b0;
    repeat (10) step();
    chk("held_thru_rst", int'(move), 0);
    btn[0] = 1'b0;
    repeat (4) step();
    btn[0] = 1'b1;
    repeat (5) step();
    chk("repress_up", int'(move), 4);
    tick_pulse();
    btn[0] = 1'b0;
    repeat (5) step();

    // confirm, with a second press before the tick
    btn[4] = 1'b1; step(); step(); btn[4] = 1'b0;
    repeat (4) step();
    chk("c_set", int'(C), 1);
    btn[4] = 1'b1; step(); step(); btn[4] = 1'b0;
    repeat (4) step();
    tick = 1'b1;
    chk("c_tick_cycle", int'(C), 1);
    step(); tick = 1'b0;
    chk("c_cleared", int'(C), 0);
    repeat (4) step();
    chk("c_stays_clear", int'(C), 0);

    // randomized traffic
    repeat (3000) begin
      for (int b = 0; b < 5; b++)
        if ($urandom_range(15) == 0) btn[b] = ~btn[b];
      tick  = ($urandom_range(4) == 0);
      reset = ($urandom_range(599) == 0);
      step();
    end
    reset = 1'b0; tick = 1'b0; btn = 5'b0;
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/maze_move_ctrl.md
MAZE_MOVE_CTRL -- requirements
Module: maze_move_ctrl

Interface
REQ-001 SHALL provide parameter SYNC_STAGES, default 2, number of synchroniser flops per button input (minimum 2).
REQ-002 SHALL provide parameter REPEAT_TICKS, default 8, number of tick strobes a direction must be held before auto-repeat.
REQ-003 SHALL have one clock and an asynchronous, active-high reset; clock and reset ports SHALL be named `clk` and `reset`.
REQ-004 SHALL have the following ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `tick` input 1: single-cycle strobe in the `clk` domain marking each move-sample instant of the maze datapath.
- `btn_u`, `btn_d`, `btn_l`, `btn_r`, `btn_c` input 1 each: raw asynchronous pushbuttons.
- `move` output 3: move code (000 stay, 001 left, 010 right, 011 down, 100 up).
- `C` output 1: confirm request.
- `pending` output 1: high while a move is armed.

Function
REQ-005 Each button SHALL pass through SYNC_STAGES flops; a press SHALL be a 0->1 transition of the synchronised level.
REQ-006 The direction FSM SHALL have three states: IDLE, ARMED and RELEASE.
REQ-007 In IDLE, a press on any direction SHALL latch its code and enter ARMED on the next `clk` edge.
- Simultaneous presses resolve by fixed priority: up > down > left > right.
REQ-008 In ARMED, `move` SHALL equal the latched code and `pending` SHALL be 1.
- New presses are ignored; the first press wins.
REQ-009 In ARMED, on the first `clk` cycle with `tick`=1, the FSM SHALL enter RELEASE.
- `move` = 000 and `pending` = 0 from the next cycle.
- The consumer samples `move` during the tick cycle.
REQ-010 A tick coincident with the press-detect cycle in IDLE SHALL NOT consume the move; consumption requires a later tick.
REQ-011 In RELEASE, `move` SHALL be 000.
- The FSM returns to IDLE on the first cycle in which all four synchronised direction levels are 0.
- Presses in RELEASE are ignored.
REQ-012 A `btn_c` press SHALL set `C`=1.
- `C` clears on the cycle after the next `tick`.
- A further press while `C`=1 has no effect.
- `C` is independent of the direction FSM.
REQ-013 `move` SHALL be a registered output and SHALL never take a value outside {000, 001, 010, 011, 100}.
REQ-014 Total press-to-`move`-valid latency SHALL be SYNC_STAGES+2 `clk` cycles: synchroniser, edge detect, latch.

Reset
REQ-015 Asserting `reset` SHALL immediately and asynchronously force:
- all synchroniser and edge-detect flops to 0
- FSM to RELEASE
- `move` = 000, `C` = 0, `pending` = 0
- repeat counter to 0
REQ-016 After reset deassertion, buttons held through reset SHALL NOT generate a move until they are released (RELEASE reset state).
REQ-017 Reset asserted while in ARMED SHALL discard the latched move; it is not presented after reset.

Configuration
REQ-018 Macro MAZE_MOVE_AUTOREPEAT_EN, when defined, SHALL enable auto-repeat:
- In RELEASE, while the highest-priority held direction is unchanged, a counter SHALL count ticks.
- When the counter reaches REPEAT_TICKS, the FSM SHALL latch that direction, enter ARMED and clear the counter.
- A change or release of the held direction SHALL clear the counter.
REQ-019 When MAZE_MOVE_AUTOREPEAT_EN is undefined, the repeat counter logic SHALL be absent and RELEASE SHALL exit only to IDLE.

Verification
REQ-020 Bench SHALL cover the following directed scenarios:
- Single press: `btn_l` pulse, tick 10 cycles later -> `move`=001 from cycle 4 through the tick cycle, then 000; `pending` mirrors.
- Priority: `btn_u` and `btn_r` rise in the same cycle -> `move`=100.
- Held through consumption: `btn_d` held across 3 ticks, no macro -> exactly one `move`=011 window, then 000 until release.
- Autorepeat (macro defined, REPEAT_TICKS=2): `btn_r` held -> `move`=010 re-armed after every 2 ticks in RELEASE.
- Reset mid-ARMED: press `btn_u`, assert `reset` in ARMED with `btn_u` still held -> `move`=000 immediately and stays 000 until `btn_u` is released and pressed again.
- Confirm: `btn_c` pulse, then tick -> `C`=1 until the cycle after the tick; a second `btn_c` press before the tick is ignored.
